// File: rtl/blackjack_pkg.sv
// Shared BlackJack definitions: delay timer FSM states and tick timing constants.
package blackjack_pkg;

    // Delay timer arbiter states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // 50 MHz system clock divided down to a 2 kHz tick
    localparam int TICK_DIV_50M_2K = 25000;

    // Two seconds expressed in 2 kHz ticks
    localparam int DELAY_2S = 4000;

endpackage

// File: rtl/delay_timer_arbiter_if.sv
// Request/grant bus between the game FSMs (master) and the shared delay timer (slave).
//
// Handshake: i_Req[k] is a level request and must stay high for as long as
// requester k wants its delay. o_Grant is one-hot while the timer is owned
// (LOAD, RUN, DONE). o_Done[k] pulses for exactly one cycle when k's delay
// has fully elapsed; dropping i_Req[k] while granted abandons the delay and
// no o_Done follows. i_Delay[k*WIDTH +: WIDTH] is captured once, in the
// cycle after the grant rises.
interface delay_timer_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 12
);
    logic [N_REQ-1:0]       i_Req;
    logic [N_REQ*WIDTH-1:0] i_Delay;
    logic [N_REQ-1:0]       o_Grant;
    logic [N_REQ-1:0]       o_Done;
    logic                   o_Busy;
    logic [WIDTH-1:0]       o_Count;

    // Requester side
    modport master (
        output i_Req,
        output i_Delay,
        input  o_Grant,
        input  o_Done,
        input  o_Busy,
        input  o_Count
    );

    // Timer side
    modport slave (
        input  i_Req,
        input  i_Delay,
        output o_Grant,
        output o_Done,
        output o_Busy,
        output o_Count
    );
endinterface

// File: rtl/delay_timer_arbiter_tick_prescaler.sv
// Divides clk_50M down to a one-cycle tick every TICK_DIV clocks.
// i_Clear restarts the division so the first tick of a grant comes a full
// period after the clear.
module tick_prescaler #(
    parameter int TICK_DIV = 25000
) (
    input  logic clk_50M,
    input  logic i_Reset_n,
    input  logic i_Clear,
    output logic o_Tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_Div;

    // Count 0..TICK_DIV-1, wrapping, restarting from 0 on clear
    always_ff @(posedge clk_50M or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Div <= '0;
        end else if (i_Clear || (r_Div == LAST)) begin
            r_Div <= '0;
        end else begin
            r_Div <= r_Div + 1'b1;
        end
    end

    assign o_Tick = (r_Div == LAST) && !i_Clear;

endmodule

// File: rtl/delay_timer_arbiter.sv
// Shared tick-based delay timer, granted round-robin to up to N_REQ game FSMs.
// The owner's delay is latched once at grant time; the owner sees a single
// o_Done pulse when the delay elapses, or nothing if it withdraws its request.
module delay_timer_arbiter
    import blackjack_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 12,
    parameter int TICK_DIV = TICK_DIV_50M_2K
) (
    input  logic                   clk_50M,
    input  logic                   i_Reset_n,
    delay_timer_arbiter_if.slave   bus,
    output state_t                 o_State
);
    localparam int IDX_W = $clog2(N_REQ);

    state_t           r_State;
    logic [IDX_W-1:0] r_Ptr;
    logic [IDX_W-1:0] r_Owner;
    logic [WIDTH-1:0] r_Target;
    logic [WIDTH-1:0] r_Count;
    logic [N_REQ-1:0] r_Grant;
    logic [N_REQ-1:0] r_Done;

    logic [IDX_W:0]   w_Pick;
    logic [WIDTH-1:0] w_Slice;
    logic [WIDTH-1:0] w_Count_Inc;
    logic             w_Tick;
    logic             w_Clear;

    // First set request at or after ptr, with wrap; MSB flags that one was found
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   result;
        logic [IDX_W-1:0] pos;
        int               idx;
        result = '0;
        // Walk from the far end so the closest candidate is written last
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            pos = IDX_W'(idx);
            if (req[pos]) begin
                result = {1'b1, pos};
            end
        end
        return result;
    endfunction

    // Pointer for the requester after the one just served
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
        int n;
        n = int'(w) + 1;
        if (n >= N_REQ) begin
            n = 0;
        end
        return IDX_W'(n);
    endfunction

    assign w_Pick      = rr_pick(bus.i_Req, r_Ptr);
    assign w_Slice     = bus.i_Delay[int'(r_Owner) * WIDTH +: WIDTH];
    assign w_Count_Inc = r_Count + 1'b1;
    assign w_Clear     = (r_State == LOAD);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk_50M   (clk_50M),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (w_Clear),
        .o_Tick    (w_Tick)
    );

    // Arbitration and delay FSM with registered grant/done/count
    always_ff @(posedge clk_50M or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State  <= IDLE;
            r_Ptr    <= '0;
            r_Owner  <= '0;
            r_Target <= '0;
            r_Count  <= '0;
            r_Grant  <= '0;
            r_Done   <= '0;
        end else begin
            r_Done <= '0;
            case (r_State)
                IDLE: begin
                    if (w_Pick[IDX_W]) begin
                        r_Owner <= w_Pick[IDX_W-1:0];
                        r_Grant <= N_REQ'(1) << w_Pick[IDX_W-1:0];
                        r_State <= LOAD;
                    end
                end
                LOAD: begin
                    r_Target <= w_Slice;
                    r_Count  <= '0;
                    if (w_Slice == '0) begin
                        r_Done  <= r_Grant;
                        r_State <= DONE;
                    end else begin
                        r_State <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.i_Req[r_Owner]) begin
                        // Owner withdrew: release silently, keep the count visible
                        r_Grant <= '0;
                        r_Ptr   <= next_ptr(r_Owner);
                        r_State <= IDLE;
                    end else if (w_Tick) begin
                        r_Count <= w_Count_Inc;
                        if (w_Count_Inc == r_Target) begin
                            r_Done  <= r_Grant;
                            r_State <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_Grant <= '0;
                    r_Ptr   <= next_ptr(r_Owner);
                    r_State <= IDLE;
                end
                default: begin
                    r_State <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Grant = r_Grant;
    assign bus.o_Done  = r_Done;
    assign bus.o_Busy  = (r_State != IDLE);
    assign bus.o_Count = r_Count;
    assign o_State     = r_State;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter: stimulus pushes expected grants and
// done pulses into queues, a negedge monitor pops them as the DUT presents them.
module tb_delay_timer_arbiter;
  import blackjack_pkg::*;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 4;
  localparam int TICK_DIV = 4;

  logic   clk_50M   = 1'b0;
  logic   i_Reset_n = 1'b0;
  state_t dbg_state;
  int     cyc       = 0;
  int     n_cmp     = 0;
  int     n_err     = 0;

  logic [N_REQ-1:0] exp_grant_q[$];
  int               exp_grant_cyc_q[$];
  logic [N_REQ-1:0] exp_done_q[$];
  int               exp_done_cyc_q[$];
  logic [WIDTH-1:0] exp_done_cnt_q[$];

  delay_timer_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  delay_timer_arbiter #(
    .N_REQ    (N_REQ),
    .WIDTH    (WIDTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk_50M   (clk_50M),
    .i_Reset_n (i_Reset_n),
    .bus       (bus),
    .o_State   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_delay(input int k, input logic [WIDTH-1:0] d);
    bus.i_Delay[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk_50M);
  endtask

  // Called at a negedge: request is sampled on the next posedge, cycle c0
  task automatic post_req(input logic [N_REQ-1:0] r, output int c0);
    bus.i_Req = r;
    c0 = cyc + 1;
  endtask

  task automatic expect_grant(input logic [N_REQ-1:0] g, input int c);
    exp_grant_q.push_back(g);
    exp_grant_cyc_q.push_back(c);
  endtask

  task automatic expect_done(input logic [N_REQ-1:0] d, input int c, input logic [WIDTH-1:0] cnt);
    exp_done_q.push_back(d);
    exp_done_cyc_q.push_back(c);
    exp_done_cnt_q.push_back(cnt);
  endtask

  task automatic pulse_reset();
    @(negedge clk_50M);
    i_Reset_n = 1'b0;
    @(negedge clk_50M);
    i_Reset_n = 1'b1;
  endtask

  task automatic print_summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [N_REQ-1:0] prev_grant = '0;

  always @(negedge clk_50M) begin : monitor
    logic [N_REQ-1:0] v;
    int               c;
    logic [WIDTH-1:0] cnt;
    if (bus.o_Done != '0) begin
      if (exp_done_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got %b expected none (cycle %0d)", bus.o_Done, cyc);
      end else begin
        v   = exp_done_q.pop_front();
        c   = exp_done_cyc_q.pop_front();
        cnt = exp_done_cnt_q.pop_front();
        check("done_value", 32'(bus.o_Done), 32'(v));
        check("done_cycle", cyc, c);
        check("done_count", 32'(bus.o_Count), 32'(cnt));
      end
    end
    if ((bus.o_Grant != prev_grant) && (bus.o_Grant != '0)) begin
      if (exp_grant_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_grant: got %b expected none (cycle %0d)", bus.o_Grant, cyc);
      end else begin
        v = exp_grant_q.pop_front();
        c = exp_grant_cyc_q.pop_front();
        check("grant_value", 32'(bus.o_Grant), 32'(v));
        check("grant_cycle", cyc, c);
      end
    end
    prev_grant = bus.o_Grant;
  end

  // ---------------- watchdog ----------------
  initial begin
    #50us;
    n_err++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    print_summary();
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int c0;
    int c1;
    bus.i_Req   = '0;
    bus.i_Delay = '0;
    repeat (2) @(negedge clk_50M);

    // Reset state
    check("rst_grant", 32'(bus.o_Grant), 0);
    check("rst_done",  32'(bus.o_Done), 0);
    check("rst_busy",  32'(bus.o_Busy), 0);
    check("rst_count", 32'(bus.o_Count), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    i_Reset_n = 1'b1;
    @(negedge clk_50M);

    // Single request, delay 3; a later delay change must be ignored
    set_delay(0, 4'd3);
    post_req(4'b0001, c0);
    expect_grant(4'b0001, c0);
    expect_done(4'b0001, c0 + 13, 4'd3);
    wait_until(c0);
    check("single_busy", 32'(bus.o_Busy), 1);
    wait_until(c0 + 2);
    set_delay(0, 4'd9);
    wait_until(c0 + 4);
    check("single_count0", 32'(bus.o_Count), 0);
    wait_until(c0 + 5);
    check("single_count1", 32'(bus.o_Count), 1);
    wait_until(c0 + 9);
    check("single_count2", 32'(bus.o_Count), 2);
    wait_until(c0 + 13);
    bus.i_Req = '0;
    wait_until(c0 + 14);
    check("single_grant_off", 32'(bus.o_Grant), 0);
    check("single_idle", 32'(bus.o_Busy), 0);
    check("single_count_hold", 32'(bus.o_Count), 3);

    // Zero delay on requester 2
    set_delay(2, 4'd0);
    post_req(4'b0100, c0);
    expect_grant(4'b0100, c0);
    expect_done(4'b0100, c0 + 1, 4'd0);
    wait_until(c0 + 1);
    check("zero_count", 32'(bus.o_Count), 0);
    bus.i_Req = '0;
    wait_until(c0 + 3);
    check("zero_idle", 32'(bus.o_Busy), 0);

    // Round robin from pointer 0, all delays 1, requests held high
    pulse_reset();
    for (int k = 0; k < N_REQ; k++) set_delay(k, 4'd1);
    post_req(4'b1111, c0);
    for (int k = 0; k < 5; k++) begin
      expect_grant(4'b0001 << (k % N_REQ), c0 + 7*k);
      expect_done(4'b0001 << (k % N_REQ), c0 + 5 + 7*k, 4'd1);
    end
    wait_until(c0 + 6);
    check("rr_gap_grant", 32'(bus.o_Grant), 0);
    check("rr_gap_busy", 32'(bus.o_Busy), 0);
    wait_until(c0 + 33);
    bus.i_Req = '0;
    wait_until(c0 + 36);
    check("rr_idle", 32'(bus.o_Busy), 0);

    // Abort: requester 1 (delay 5) drops after 2 ticks, requester 3 pending
    set_delay(1, 4'd5);
    set_delay(3, 4'd1);
    post_req(4'b1010, c0);
    expect_grant(4'b0010, c0);
    expect_grant(4'b1000, c0 + 11);
    expect_done(4'b1000, c0 + 16, 4'd1);
    wait_until(c0 + 9);
    check("abort_count2", 32'(bus.o_Count), 2);
    bus.i_Req = 4'b1000;
    wait_until(c0 + 10);
    check("abort_grant_off", 32'(bus.o_Grant), 0);
    check("abort_idle", 32'(bus.o_Busy), 0);
    check("abort_count_hold", 32'(bus.o_Count), 2);
    wait_until(c0 + 11);
    check("abort_count_load", 32'(bus.o_Count), 2);
    wait_until(c0 + 16);
    bus.i_Req = '0;
    wait_until(c0 + 18);

    // Reset mid-RUN on requester 2, then requester 0 wins after release
    set_delay(2, 4'd5);
    post_req(4'b0100, c0);
    expect_grant(4'b0100, c0);
    wait_until(c0 + 9);
    check("mid_count2", 32'(bus.o_Count), 2);
    #2;
    i_Reset_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(bus.o_Grant), 0);
    check("mid_rst_done",  32'(bus.o_Done), 0);
    check("mid_rst_busy",  32'(bus.o_Busy), 0);
    check("mid_rst_count", 32'(bus.o_Count), 0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk_50M);
    i_Reset_n = 1'b1;
    set_delay(0, 4'd1);
    set_delay(2, 4'd0);
    post_req(4'b0101, c1);
    expect_grant(4'b0001, c1);
    expect_done(4'b0001, c1 + 5, 4'd1);
    expect_grant(4'b0100, c1 + 7);
    expect_done(4'b0100, c1 + 8, 4'd0);
    wait_until(c1 + 5);
    bus.i_Req = 4'b0100;
    wait_until(c1 + 8);
    bus.i_Req = '0;
    wait_until(c1 + 10);

    // Maximum delay 15 with 4-bit count
    set_delay(0, 4'd15);
    post_req(4'b0001, c0);
    expect_grant(4'b0001, c0);
    expect_done(4'b0001, c0 + 61, 4'd15);
    wait_until(c0 + 60);
    check("max_count14", 32'(bus.o_Count), 14);
    wait_until(c0 + 61);
    bus.i_Req = '0;
    wait_until(c0 + 62);
    check("max_count_hold", 32'(bus.o_Count), 15);
    check("max_idle", 32'(bus.o_Busy), 0);
    wait_until(c0 + 64);

    // Everything expected has been observed
    check("grant_q_drained", exp_grant_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);

    print_summary();
    $finish;
  end

endmodule
